// File: rtl/stack_pkg.sv
// Shared definitions for the stack host and the stack device: default sizes,
// op encoding, response codes and the host FSM state type.
// Ports: none (package).
package stack_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    RSP_OK  = 2'b00,
    RSP_OVF = 2'b01,
    RSP_UDF = 2'b10,
    RSP_TMO = 2'b11
  } rsp_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/stack_host_watchdog.sv
// Purpose: counts stalled WAIT cycles and flags the one on which the host must abort.
// Latency: expired is combinational on enable and the current count, so the abort happens in that same cycle.
// Backpressure: none. Ports: clk, rst_n, clear (restart count), enable (stalled cycle), expired.
module stack_host_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + WW'(1);
    end
  end

  // cnt holds the number of earlier stalled cycles, so the TIMEOUT-th stalled
  // cycle is the one that sees TIMEOUT-1.
  assign expired = enable && (cnt == WW'(TIMEOUT - 1));

endmodule

// File: rtl/stack_host.sv
// Purpose: accepts push/pop commands, drives one strobe to an external stack device, tracks a shadow occupancy.
// Latency: rejects answer 1 cycle after the handshake; issued commands answer after ISSUE plus the WAIT cycles.
// Backpressure: one command in flight; cmd_ready only in IDLE; RESP holds until rsp_ready.
// Ports: cmd_* request channel, rsp_* response channel, stk_* device strobes/data, count shadow occupancy.
module stack_host
  import stack_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_op,
  input  logic [WIDTH-1:0]       cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_code,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic [WIDTH-1:0]       stk_wdata,
  input  logic [WIDTH-1:0]       stk_rdata,
  input  logic                   stk_done,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  rsp_code_e        code_q, code_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wd_expired;

  // Watchdog restarts while in ISSUE so it reads zero on the first WAIT cycle.
  stack_host_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == ST_ISSUE),
    .enable  ((state_q == ST_WAIT) && !stk_done),
    .expired (wd_expired)
  );

  // Strobes and response valid decode straight from state, so a reset edge
  // drops them together with the state.
  assign cmd_ready = rst_n && (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_code  = code_q;
  assign rsp_data  = rdata_q;
  assign stk_push  = (state_q == ST_ISSUE) && (op_q == OP_PUSH);
  assign stk_pop   = (state_q == ST_ISSUE) && (op_q == OP_POP);
  assign stk_wdata = (state_q == ST_ISSUE) ? data_q : '0;
  assign count     = cnt_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          rdata_d = '0;
          if ((cmd_op == OP_PUSH) && (cnt_q == FULL)) begin
            state_d = ST_RESP;
            code_d  = RSP_OVF;
          end else if ((cmd_op == OP_POP) && (cnt_q == '0)) begin
            state_d = ST_RESP;
            code_d  = RSP_UDF;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (stk_done) begin
          state_d = ST_RESP;
          code_d  = RSP_OK;
          if (op_q == OP_PUSH) begin
            if (cnt_q != FULL) cnt_d = cnt_q + CW'(1);
            rdata_d = '0;
          end else begin
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            rdata_d = stk_rdata;
          end
        end else if (wd_expired) begin
          state_d = ST_RESP;
          code_d  = RSP_TMO;
          rdata_d = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          code_d  = RSP_OK;
          rdata_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 1'b0;
      data_q  <= '0;
      rdata_q <= '0;
      code_q  <= RSP_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stack_host.sv
// Purpose: directed plus randomized test of stack_host against a queue-based stack reference and a device model.
// Latency: checks response timing counted in cycles from the handshake cycle to the first rsp_valid cycle.
// Backpressure: exercises rsp_ready held low in RESP and a reset abandoning an in-flight command.
module tb_stack_host;
  import stack_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 15;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_code;
  logic [7:0] rsp_data;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_wdata;
  logic [7:0] stk_rdata;
  logic       stk_done;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  // Reference: the stack contents and occupancy the host should believe in.
  logic [7:0] mstack[$];
  int         mcount = 0;
  // Device model: what the external stack actually holds.
  logic [7:0] dev_q[$];

  stack_host #(.WIDTH(8), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_code  (rsp_code),
    .rsp_data  (rsp_data),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata),
    .stk_done  (stk_done),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // delay: stalled WAIT cycles before stk_done; delay >= TIMEOUT means never.
  // hold: cycles rsp_ready stays low once the response is visible.
  task automatic run_cmd(input logic op, input logic [7:0] d, input int delay, input int hold);
    logic [1:0] ecode;
    logic [7:0] edata;
    logic [7:0] dev_word;
    logic [1:0] c0;
    logic [7:0] d0;
    logic [4:0] n0;
    int         elat, lat, npush, npop;
    bit         wbad, hold_bad;
    edata    = 8'h00;
    dev_word = 8'h00;
    if (op == OP_PUSH && mcount == DEPTH) begin
      ecode = 2'b01; elat = 1;
    end else if (op == OP_POP && mcount == 0) begin
      ecode = 2'b10; elat = 1;
    end else if (delay >= TIMEOUT) begin
      ecode = 2'b11; elat = 2 + TIMEOUT;
    end else begin
      ecode = 2'b00; elat = 3 + delay;
      if (op == OP_PUSH) begin
        mstack.push_back(d); mcount++;
      end else begin
        edata = mstack.pop_back(); mcount--;
      end
    end

    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 1'($urandom); cmd_data = 8'($urandom);
    lat = 0; npush = 0; npop = 0; wbad = 0;
    for (int i = 0; i < 40; i++) begin
      if (stk_push) begin
        npush++;
        dev_q.push_back(stk_wdata);
        if (stk_wdata !== d) wbad = 1;
      end
      if (stk_pop) begin
        npop++;
        if (dev_q.size() > 0) dev_word = dev_q.pop_back();
      end
      if (!stk_push && !stk_pop && stk_wdata !== 8'h00) wbad = 1;
      if (stk_push && stk_pop) wbad = 1;
      if (rsp_valid) begin
        lat = i + 1;
        break;
      end
      stk_done  = (i == 1 + delay);
      stk_rdata = stk_done ? dev_word : 8'($urandom);
      @(posedge clk); #1;
    end
    stk_done = 1'b0; stk_rdata = 8'($urandom);

    // An aborted operation is rolled back in the device model.
    if (ecode == 2'b11) begin
      if (op == OP_PUSH && npush > 0 && dev_q.size() > 0) void'(dev_q.pop_back());
      if (op == OP_POP && npop > 0) dev_q.push_back(dev_word);
    end

    check("rsp_latency", lat, elat);
    check("push_strobes", npush, (op == OP_PUSH && ecode[1] == ecode[0]) ? 1 : 0);
    check("pop_strobes", npop, (op == OP_POP && ecode[1] == ecode[0]) ? 1 : 0);
    check("strobe_wdata_ok", wbad, 0);
    check("rsp_code", rsp_code, ecode);
    check("rsp_data", rsp_data, edata);
    check("count", count, mcount);

    c0 = rsp_code; d0 = rsp_data; n0 = count; hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      stk_done = 1'($urandom);
      @(posedge clk); #1;
      if (!rsp_valid || rsp_code !== c0 || rsp_data !== d0 || cmd_ready !== 1'b0 || count !== n0)
        hold_bad = 1;
    end
    stk_done = 1'b0;
    check("resp_stable_hold", hold_bad, 0);
    rsp_ready = 1'b1;
    check("ready_during_consume", cmd_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_after_consume", rsp_valid, 0);
  endtask

  initial begin
    int op, dl;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = 8'h00;
    rsp_ready = 1'b0; stk_rdata = 8'h00; stk_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_outputs", {stk_push, stk_pop, stk_wdata, rsp_code, rsp_data}, 0);
    check("reset_count", count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd(OP_PUSH, 8'hA5, 0, 0);
    run_cmd(OP_POP,  8'h00, 3, 0);
    run_cmd(OP_PUSH, 8'h3C, 1, 0);
    run_cmd(OP_POP,  8'h00, 3, 0);
    run_cmd(OP_POP,  8'h00, 0, 0);
    for (int i = 0; i < DEPTH; i++) run_cmd(OP_PUSH, 8'($urandom), int'($urandom_range(0, 4)), 0);
    run_cmd(OP_PUSH, 8'h77, 0, 0);
    run_cmd(OP_POP, 8'h00, 2, 0);
    run_cmd(OP_PUSH, 8'h5A, 99, 0);

    // Late completion after an abort must not move the occupancy.
    stk_done = 1'b1;
    @(posedge clk); #1;
    stk_done = 1'b0;
    @(posedge clk); #1;
    check("late_done_count", count, mcount);

    run_cmd(OP_POP, 8'h00, 1, 5);

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 1));
      dl = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 5));
      run_cmd(1'(op), 8'($urandom), dl, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of WAIT abandons the command silently.
    run_cmd(OP_PUSH, 8'h11, 0, 0);
    check("ready_before_abort", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_data = 8'h99;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready_low", cmd_ready, 0);
    @(posedge clk); #1;
    check("abort_outputs", {rsp_valid, stk_push, stk_pop, stk_wdata, rsp_code, rsp_data}, 0);
    check("abort_count", count, 0);
    mcount = 0; mstack.delete(); dev_q.delete();
    rst_n = 1'b1;
    begin
      bit quiet_bad;
      quiet_bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (rsp_valid || stk_push || stk_pop) quiet_bad = 1;
      end
      check("abort_no_response", quiet_bad, 0);
    end
    check("abort_idle_ready", cmd_ready, 1);
    run_cmd(OP_PUSH, 8'hC3, 0, 0);
    run_cmd(OP_POP, 8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
